// File: rtl/reg_lock_mgr.sv
// Register-lock scoreboard and decode->execute issue gate (RAW/WAW hazards, jump lock-all).
// Optional macro REG_LOCK_BYPASS_EN: same-cycle writebacks are hidden from the hazard check.
module reg_lock_mgr #(
  parameter int NR     = 64,
  parameter int NUM_WB = 2,
  localparam int RW    = $clog2(NR)
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic               pl_valid_i,
  output logic               pl_ready_o,
  input  logic               jump_i,
  input  logic [RW-1:0]      rd_i,
  input  logic [NR-1:0]      reg_req_i,
  output logic               issue_valid_o,
  input  logic               issue_ready_i,
  input  logic [NUM_WB-1:0]  wb_valid_i,
  input  logic [NUM_WB*RW-1:0] wb_rd_i,
  input  logic               jump_done_i,
  input  logic               flush_i,
  output logic [NR-1:0]      locks_o,
  output logic [RW:0]        lock_cnt_o,
  output logic               jump_wait_o
);

  typedef enum logic {RUN = 1'b0, JUMP = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [NR-1:0]   locks_q, locks_d;
  logic [NR-1:0]   wb_clr;
  logic [NR-1:0]   lk;
  logic [NR-1:0]   set_vec;
  logic [RW-1:0]   wb_idx;
  logic [RW:0]     cnt;
  logic            hazard;
  logic            fire;

  always_comb begin
    wb_clr = '0;
    wb_idx = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      wb_idx = wb_rd_i[k*RW +: RW];
      if (wb_valid_i[k] && (wb_idx != '0)) wb_clr[wb_idx] = 1'b1;
    end
  end

`ifdef REG_LOCK_BYPASS_EN
  assign lk = locks_q & ~wb_clr;
`else
  assign lk = locks_q;
`endif

  // WAW term applies to jumps too: a jump writing a locked rd must still wait.
  assign hazard = (|(lk & reg_req_i)) | (lk[rd_i] & (rd_i != '0));

  // Handshake: decode offers pl_valid_i; the instruction is consumed (fire) only in
  // the cycle pl_valid_i & pl_ready_o; issue_valid_o is a zero-latency pass-through
  // and pl_ready_o = issue_valid_o & issue_ready_i, so decode and execute fire together.
  always_comb begin
    issue_valid_o = 1'b0;
    pl_ready_o    = 1'b0;
    state_d       = state_q;
    locks_d       = locks_q;
    set_vec       = '0;
    if (state_q == RUN) begin
      issue_valid_o = pl_valid_i & ~hazard & ~flush_i;
      pl_ready_o    = issue_valid_o & issue_ready_i;
    end
    fire = pl_valid_i & pl_ready_o;
    if (fire && !jump_i && (rd_i != '0)) set_vec[rd_i] = 1'b1;

    if (flush_i) begin
      locks_d = '0;
      state_d = RUN;
    end else if (state_q == JUMP) begin
      if (jump_done_i) begin
        locks_d = '0;
        state_d = RUN;
      end else begin
        locks_d = '1;
      end
    end else if (fire && jump_i) begin
      locks_d = '1;
      state_d = JUMP;
    end else begin
      // Set after clear so a new writer keeps the lock over a same-cycle writeback.
      locks_d = (locks_q & ~wb_clr) | set_vec;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= RUN;
      locks_q <= '0;
    end else begin
      state_q <= state_d;
      locks_q <= locks_d;
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NR; i++) cnt = cnt + (RW+1)'(locks_q[i]);
  end

  assign locks_o     = locks_q;
  assign lock_cnt_o  = cnt;
  assign jump_wait_o = (state_q == JUMP);

endmodule
